// File: rtl/pio_arb_pkg.sv
// Shared types and constants for the PIO read arbiter.
// State encoding, default slave widths and a small index helper.
package pio_arb_pkg;

  localparam int unsigned ADDR_W = 2;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {IDLE, ADDR, WAIT, DONE} arb_state_t;

  // (v + 1) mod n, for requester indices
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/pio_rr_select.sv
// Combinational requester selector: first eligible request at or after the
// start index, wrapping. A start index of zero gives lowest-index-first priority.
module pio_rr_select #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] mask,
  input  logic [PTR_W-1:0] start,
  output logic             grant_valid,
  output logic [PTR_W-1:0] grant_idx
);

  logic [N_REQ-1:0] eligible;
  int unsigned      pos;

  assign eligible = req & ~mask;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    pos         = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      pos = 32'(start) + i;
      if (pos >= N_REQ) begin
        pos = pos - N_REQ;
      end
      if (!grant_valid && eligible[pos[PTR_W-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = pos[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/pio_read_arbiter.sv
// Shares one registered-latency Avalon-MM read PIO among N_REQ requesters.
// Define PIO_ARB_ROUND_ROBIN_EN for round-robin selection; default is fixed priority.
module pio_read_arbiter #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned ADDR_W = pio_arb_pkg::ADDR_W,
  parameter int unsigned DATA_W = pio_arb_pkg::DATA_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  output logic [N_REQ-1:0]        ack,
  output logic [DATA_W-1:0]       rdata,
  output logic                    busy,
  output logic [ADDR_W-1:0]       slv_address,
  input  logic [DATA_W-1:0]       slv_readdata
);
  import pio_arb_pkg::*;

  localparam int unsigned PtrW = $clog2(N_REQ);

  arb_state_t        state_q, state_d;
  logic [PtrW-1:0]   g_q, g_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [N_REQ-1:0]  mask;
  logic [PtrW-1:0]   start_ptr;
  logic              grant_valid;
  logic [PtrW-1:0]   grant_idx;
  logic              load;
  logic [ADDR_W-1:0] addr_arr [N_REQ];

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  // The requester being acked may still hold req during DONE
  always_comb begin
    mask = '0;
    if (state_q == DONE) begin
      mask[g_q] = 1'b1;
    end
  end

  pio_rr_select #(
    .N_REQ (N_REQ),
    .PTR_W (PtrW)
  ) u_select (
    .req         (req),
    .mask        (mask),
    .start       (start_ptr),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (grant_valid) begin
          load    = 1'b1;
          g_d     = grant_idx;
          addr_d  = addr_arr[grant_idx];
          state_d = ADDR;
        end else begin
          state_d = IDLE;
        end
      end
      ADDR: state_d = WAIT;
      WAIT: begin
        rdata_d = slv_readdata;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      g_q     <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef PIO_ARB_ROUND_ROBIN_EN
  logic [PtrW-1:0] rr_q, rr_d;

  assign start_ptr = rr_q;

  always_comb begin
    rr_d = rr_q;
    if (load) begin
      rr_d = PtrW'(wrap_inc(32'(grant_idx), N_REQ));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end
`else
  assign start_ptr = '0;
`endif

  always_comb begin
    ack = '0;
    if (state_q == DONE) begin
      ack[g_q] = 1'b1;
    end
  end

  assign rdata       = rdata_q;
  assign busy        = (state_q != IDLE);
  assign slv_address = addr_q;

endmodule

// File: tb/tb_pio_read_arbiter.sv
// Directed bench for pio_read_arbiter: vector table of single reads plus
// hand-written contention, address-change, reset and request-drop sequences.
module tb_pio_read_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [7:0]  req_addr;
  logic [3:0]  ack;
  logic [31:0] rdata;
  logic        busy;
  logic [1:0]  slv_address;
  logic [31:0] slv_readdata;
  logic [31:0] mem [4];

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  pio_read_arbiter #(
    .N_REQ  (4),
    .ADDR_W (2),
    .DATA_W (32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .req_addr     (req_addr),
    .ack          (ack),
    .rdata        (rdata),
    .busy         (busy),
    .slv_address  (slv_address),
    .slv_readdata (slv_readdata)
  );

  // Registered-readdata PIO model
  always @(posedge clk) slv_readdata <= mem[slv_address];

  typedef struct {
    logic [3:0] req;
    logic [7:0] addr;
    int         exp_fp;
    int         exp_rr;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wait_ack(output int lat, output logic [3:0] a);
    lat = 0;
    a   = '0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      lat++;
      if (ack !== 4'b0000) begin
        a = ack;
        break;
      end
    end
  endtask

  task automatic count_acks(input int cycles, output int cnt);
    cnt = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (ack !== 4'b0000) cnt++;
    end
  endtask

  initial begin
    int         lat;
    int         cnt;
    int         e;
    int         exp2 [5];
    int         exp3 [4];
    logic [3:0] a;
    logic [7:0] tmp;
    logic [1:0] ea;

    mem[0] = 32'hDEADBEEF;
    mem[1] = 32'h12345678;
    mem[2] = 32'hA5A55A5A;
    mem[3] = 32'hCAFEF00D;

    vecs[0] = '{req: 4'b0001, addr: 8'b00_00_00_00, exp_fp: 0, exp_rr: 0};
    vecs[1] = '{req: 4'b0100, addr: 8'b00_10_00_00, exp_fp: 2, exp_rr: 2};
    vecs[2] = '{req: 4'b1010, addr: 8'b11_00_01_00, exp_fp: 1, exp_rr: 3};
    vecs[3] = '{req: 4'b1111, addr: 8'b00_01_10_11, exp_fp: 0, exp_rr: 0};
    vecs[4] = '{req: 4'b1100, addr: 8'b10_01_00_00, exp_fp: 2, exp_rr: 2};
    vecs[5] = '{req: 4'b1001, addr: 8'b01_00_00_10, exp_fp: 0, exp_rr: 3};
    vecs[6] = '{req: 4'b1000, addr: 8'b11_00_00_00, exp_fp: 3, exp_rr: 3};

`ifdef PIO_ARB_ROUND_ROBIN_EN
    exp2 = '{0, 1, 2, 3, 0};
`else
    exp2 = '{0, 1, 0, 1, 0};
`endif
    exp3 = '{1, 2, 1, 2};

    reset    = 1'b1;
    req      = '0;
    req_addr = '0;
    #1;
    check("rst_ack", 32'(ack), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_rdata", rdata, 0);
    check("rst_addr", 32'(slv_address), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Single reads from idle
    for (int i = 0; i < 7; i++) begin
`ifdef PIO_ARB_ROUND_ROBIN_EN
      e = vecs[i].exp_rr;
`else
      e = vecs[i].exp_fp;
`endif
      tmp      = vecs[i].addr;
      ea       = tmp[e*2 +: 2];
      req      = vecs[i].req;
      req_addr = vecs[i].addr;
      wait_ack(lat, a);
      req = '0;
      check($sformatf("vec%0d_ack", i), 32'(a), 32'(1) << e);
      check($sformatf("vec%0d_lat", i), lat, 3);
      check($sformatf("vec%0d_addr", i), 32'(slv_address), 32'(ea));
      check($sformatf("vec%0d_rdata", i), rdata, mem[ea]);
      check($sformatf("vec%0d_busy", i), 32'(busy), 1);
      @(negedge clk);
      check($sformatf("vec%0d_idle_ack", i), 32'(ack), 0);
      check($sformatf("vec%0d_idle_busy", i), 32'(busy), 0);
    end

    // Contention, all requesters held
    req      = 4'b1111;
    req_addr = 8'b11_10_01_00;
    for (int k = 0; k < 5; k++) begin
      wait_ack(lat, a);
      if (k == 4) req = '0;
      check($sformatf("t2_ack%0d", k), 32'(a), 32'(1) << exp2[k]);
      check($sformatf("t2_lat%0d", k), lat, 3);
      check($sformatf("t2_rdata%0d", k), rdata, mem[exp2[k]]);
      check($sformatf("t2_busy%0d", k), 32'(busy), 1);
    end
    @(negedge clk);
    check("t2_idle", 32'(busy), 0);

    // Requesters 1 and 2 held, then req[1] drops
    req      = 4'b0110;
    req_addr = 8'b00_10_01_00;
    for (int k = 0; k < 4; k++) begin
      wait_ack(lat, a);
      if (k == 2) req = 4'b0100;
      if (k == 3) req = 4'b0000;
      check($sformatf("t3_ack%0d", k), 32'(a), 32'(1) << exp3[k]);
      check($sformatf("t3_rdata%0d", k), rdata, mem[exp3[k]]);
      check($sformatf("t3_lat%0d", k), lat, 3);
    end
    @(negedge clk);
    check("t3_idle", 32'(busy), 0);

    // Address change after grant is ignored
    req      = 4'b0010;
    req_addr = 8'b00_00_00_00;
    @(negedge clk);
    @(negedge clk);
    req_addr = 8'b00_00_11_00;
    check("t4_addr_wait", 32'(slv_address), 0);
    wait_ack(lat, a);
    req = '0;
    check("t4_ack", 32'(a), 32'b0010);
    check("t4_rdata", rdata, mem[0]);
    check("t4_addr_done", 32'(slv_address), 0);
    @(negedge clk);

    // Reset during WAIT abandons the read
    req      = 4'b0100;
    req_addr = 8'b00_01_00_00;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    req   = '0;
    #1;
    check("t5_ack", 32'(ack), 0);
    check("t5_busy", 32'(busy), 0);
    check("t5_rdata", rdata, 0);
    check("t5_addr", 32'(slv_address), 0);
    @(negedge clk);
    reset = 1'b0;
    count_acks(5, cnt);
    check("t5_noack", cnt, 0);
    req = 4'b0100;
    wait_ack(lat, a);
    req = '0;
    check("t5_next_ack", 32'(a), 32'b0100);
    check("t5_next_lat", lat, 3);
    check("t5_next_rdata", rdata, mem[1]);
    @(negedge clk);

    // Request dropped during ADDR still completes
    req      = 4'b0100;
    req_addr = 8'b00_10_00_00;
    @(negedge clk);
    req = '0;
    wait_ack(lat, a);
    check("t6_ack", 32'(a), 32'b0100);
    check("t6_lat", lat, 2);
    check("t6_rdata", rdata, mem[2]);
    @(negedge clk);
    check("t6_idle", 32'(busy), 0);
    count_acks(5, cnt);
    check("t6_noack", cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
